// File: rtl/display_arbiter_pkg.sv
// Shared types and helpers for the display arbiter.
// Optional blank gap between owners is enabled with the DISP_ARB_BLANK_EN macro.
package display_arbiter_pkg;

   localparam int VALUE_W = 32;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_HOLD  = 2'd1,
      ARB_BLANK = 2'd2
   } arb_state_t;

   // Width of an index/counter able to hold 0..n-1, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Requester/display bundle between value producers and the display arbiter.
// Optional blank gap between owners is enabled with the DISP_ARB_BLANK_EN macro.
interface display_arbiter_if #(
   parameter int NREQ = 4
);
   import display_arbiter_pkg::*;

   localparam int OWNER_W = clog2_min1(NREQ);

   // req[i] is a level held for as long as requester i wants the display; gnt is the
   // registered one-hot answer, and value_out follows the granted value_in slice.
   logic [NREQ-1:0]         req;
   logic [VALUE_W*NREQ-1:0] value_in;
   logic [NREQ-1:0]         gnt;
   logic [OWNER_W-1:0]      owner;
   logic [VALUE_W-1:0]      value_out;
   logic                    busy;
   arb_state_t              state;

   modport master (
      output req, value_in,
      input  gnt, owner, value_out, busy, state
   );

   modport slave (
      input  req, value_in,
      output gnt, owner, value_out, busy, state
   );

endinterface

// File: rtl/display_arbiter_rr_picker.sv
// Combinational round-robin search: first set request strictly after pointer, wrapping.
// Optional blank gap between owners is enabled with the DISP_ARB_BLANK_EN macro.
module rr_picker #(
   parameter int NREQ  = 4,
   parameter int IDX_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] pointer,
   output logic             found,
   output logic [IDX_W-1:0] index
);

   int cand;

   always_comb begin
      found = 1'b0;
      index = '0;
      cand  = 0;
      // The pointer itself is scanned last so the current holder loses ties.
      for (int off = 1; off <= NREQ; off++) begin
         cand = (int'(pointer) + off) % NREQ;
         if (!found && req[IDX_W'(cand)]) begin
            found = 1'b1;
            index = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the shared 8-digit display with a minimum hold per owner.
// Define DISP_ARB_BLANK_EN to insert a blank gap of BLANK_CYCLES between owners.
module display_arbiter
   import display_arbiter_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int HOLD_CYCLES  = 50000000,
   parameter int BLANK_CYCLES = 5000000
) (
   input  logic            clk,
   input  logic            reset,
   display_arbiter_if.slave bus
);

   localparam int IDX_W = clog2_min1(NREQ);
   localparam int CNT_W = clog2_min1(max_int(HOLD_CYCLES, BLANK_CYCLES));

   arb_state_t           state_q, state_d;
   logic [NREQ-1:0]      gnt_q, gnt_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [VALUE_W-1:0]   value_q, value_d;
   logic                 busy_q, busy_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;

   logic [IDX_W-1:0]     pick_ptr;
   logic                 found;
   logic [IDX_W-1:0]     pick_idx;
   logic                 owner_req;
   logic                 others;
   logic                 do_grant;
   logic [VALUE_W-1:0]   winner_value;
   logic [VALUE_W-1:0]   owner_value;

   // While holding, the search starts after the owner so a release hands over in RR order.
   assign pick_ptr = (state_q == ARB_HOLD) ? owner_q : ptr_q;

   rr_picker #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req     (bus.req),
      .pointer (pick_ptr),
      .found   (found),
      .index   (pick_idx)
   );

   assign owner_req    = bus.req[owner_q];
   assign others       = |(bus.req & ~gnt_q);
   assign winner_value = bus.value_in[pick_idx*VALUE_W +: VALUE_W];
   assign owner_value  = bus.value_in[owner_q*VALUE_W +: VALUE_W];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         value_q <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         ptr_q   <= IDX_W'(NREQ - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         value_q <= value_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      owner_d  = owner_q;
      value_d  = value_q;
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      do_grant = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            if (found) do_grant = 1'b1;
         end

         ARB_HOLD: begin
            if (!owner_req || ((cnt_q == '0) && others)) begin
               ptr_d = owner_q;
               if (found) begin
`ifdef DISP_ARB_BLANK_EN
                  state_d = ARB_BLANK;
                  gnt_d   = '0;
                  busy_d  = 1'b1;
                  value_d = '0;
                  cnt_d   = CNT_W'(BLANK_CYCLES - 1);
`else
                  do_grant = 1'b1;
`endif
               end else begin
                  state_d = ARB_IDLE;
                  gnt_d   = '0;
                  busy_d  = 1'b0;
               end
            end else begin
               // Saturating at zero keeps the owner until someone else asks.
               value_d = owner_value;
               if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
         end

`ifdef DISP_ARB_BLANK_EN
         ARB_BLANK: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (found) begin
               do_grant = 1'b1;
            end else begin
               state_d = ARB_IDLE;
               busy_d  = 1'b0;
            end
         end
`endif

         default: begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase

      if (do_grant) begin
         state_d         = ARB_HOLD;
         gnt_d           = '0;
         gnt_d[pick_idx] = 1'b1;
         owner_d         = pick_idx;
         value_d         = winner_value;
         busy_d          = 1'b1;
         cnt_d           = CNT_W'(HOLD_CYCLES - 1);
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.owner     = owner_q;
   assign bus.value_out = value_q;
   assign bus.busy      = busy_q;
   assign bus.state     = state_q;

endmodule
